// File: rtl/fixpoint_mult_pipe_pkg.sv
// -----------------------------------------------------------------------------
// fixpoint_mult_pipe_pkg
// Shared fixed-point helpers used by the multiplier pipeline and the adder
// stage: product width derivations and the saturation end-point constants.
// No ports; import with "import fixpoint_mult_pipe_pkg::*;".
// -----------------------------------------------------------------------------
package fixpoint_mult_pipe_pkg;

   // Widest word the saturation helpers can describe.
   localparam int FX_MAX_W = 64;

   typedef logic [FX_MAX_W-1:0] fx_word_t;

   // Integer bits (sign included) of the exact product of two fixed-point operands.
   function automatic int fx_int_p(input int wi1, input int wi2);
      return wi1 + wi2;
   endfunction

   // Fraction bits of the exact product of two fixed-point operands.
   function automatic int fx_frc_p(input int wf1, input int wf2);
      return wf1 + wf2;
   endfunction

   // Largest positive two's-complement value of width w: 0 followed by all ones.
   function automatic fx_word_t fx_sat_max(input int w);
      return (fx_word_t'(64'd1) << (w - 32'sd1)) - fx_word_t'(64'd1);
   endfunction

   // Most negative two's-complement value of width w: 1 followed by all zeros.
   function automatic fx_word_t fx_sat_min(input int w);
      return fx_word_t'(64'd1) << (w - 32'sd1);
   endfunction

endpackage

// File: rtl/fixpoint_mult_pipe_if.sv
// -----------------------------------------------------------------------------
// fixpoint_mult_pipe_if
// Valid/ready stream bundle around the fixed-point multiplier.
//   in_valid/in_ready/in1/in2 : operand pair stream into the block
//   out_valid/out_ready/out   : product stream towards the adder stage
//   OVF                       : saturation flag, aligned with out_valid
// slave  : the multiplier side
// master : the producer/consumer side
// -----------------------------------------------------------------------------
interface fixpoint_mult_pipe_if #(
   parameter int W1 = 7,
   parameter int W2 = 11,
   parameter int WO = 16
) ();

   logic          in_valid;
   logic          in_ready;
   logic [W1-1:0] in1;
   logic [W2-1:0] in2;
   logic          out_valid;
   logic          out_ready;
   logic [WO-1:0] out;
   logic          OVF;

   modport slave (
      input  in_valid, in1, in2, out_ready,
      output in_ready, out_valid, out, OVF
   );

   modport master (
      output in_valid, in1, in2, out_ready,
      input  in_ready, out_valid, out, OVF
   );

endinterface

// File: rtl/fixpoint_mult_pipe_resize.sv
// -----------------------------------------------------------------------------
// fixpoint_resize
// Combinational format conversion of a signed fixed-point word
// Q(WII).(WFI) -> Q(WIO).(WFO).
//   din  : input word, WII+WFI bits, signed
//   dout : converted word, WIO+WFO bits, signed
//   ovf  : 1 when dout was saturated
// Fraction: zero-append when widening, floor (drop LSBs) when narrowing.
// Integer : sign-extend when widening, saturate when narrowing and the
//           discarded MSBs are not a pure sign extension.
// -----------------------------------------------------------------------------
module fixpoint_resize
   import fixpoint_mult_pipe_pkg::*;
#(
   parameter int WII = 10,
   parameter int WFI = 8,
   parameter int WIO = 1,
   parameter int WFO = 15
) (
   input  logic [WII+WFI-1:0] din,
   output logic [WIO+WFO-1:0] dout,
   output logic               ovf
);

   localparam int WIN  = WII + WFI;
   localparam int WOUT = WIO + WFO;
   localparam int WFX  = WII + WFO;   // input integer bits, output fraction bits

   localparam logic [WOUT-1:0] SAT_MAX = WOUT'(fx_sat_max(WOUT));
   localparam logic [WOUT-1:0] SAT_MIN = WOUT'(fx_sat_min(WOUT));

   logic [WFX-1:0] fx_s;

   generate
      if (WFO > WFI) begin : g_frac_ext
         assign fx_s = {din, {(WFO-WFI){1'b0}}};
      end else if (WFO == WFI) begin : g_frac_same
         assign fx_s = din;
      end else begin : g_frac_trunc
         // Dropping LSBs of a two's-complement word rounds toward minus infinity.
         logic drop_unused_s;
         assign fx_s          = din[WIN-1 -: WFX];
         assign drop_unused_s = ^din[WFI-WFO-1:0];
      end

      if (WIO >= WII) begin : g_int_ext
         assign dout = WOUT'($signed(fx_s));
         assign ovf  = 1'b0;
      end else begin : g_int_sat
         // Discarded MSBs plus the surviving sign bit must all agree to fit.
         logic [WII-WIO:0] disc_s;
         logic             fits_s;

         assign disc_s = fx_s[WFX-1:WOUT-1];
         assign fits_s = (&disc_s) | (~|disc_s);

         // Pass through when the value fits, otherwise clamp toward the sign.
         always_comb begin
            dout = fx_s[WOUT-1:0];
            ovf  = 1'b0;
            if (fits_s) begin
               dout = fx_s[WOUT-1:0];
               ovf  = 1'b0;
            end else if (fx_s[WFX-1]) begin
               dout = SAT_MIN;
               ovf  = 1'b1;
            end else begin
               dout = SAT_MAX;
               ovf  = 1'b1;
            end
         end
      end
   endgenerate

endmodule

// File: rtl/fixpoint_mult_pipe.sv
// -----------------------------------------------------------------------------
// fixpoint_mult_pipe
// Three-stage signed fixed-point multiplier with valid/ready flow control.
//   CLK : clock, rising edge
//   RST : asynchronous reset, active low
//   bus : fixpoint_mult_pipe_if.slave
//         in1  Q(WI1).(WF1), in2 Q(WI2).(WF2), out Q(WIO).(WFO), OVF
// Stages: S1 operands, S2 exact product, S3 formatted result + OVF.
// A single advance enable (en = !out_valid || out_ready) moves the whole
// pipeline, so bubbles travel with the data and nothing is lost or repeated.
// -----------------------------------------------------------------------------
module fixpoint_mult_pipe
   import fixpoint_mult_pipe_pkg::*;
#(
   parameter int WI1 = 4,
   parameter int WF1 = 3,
   parameter int WI2 = 6,
   parameter int WF2 = 5,
   parameter int WIO = 1,
   parameter int WFO = 15
) (
   input  logic               CLK,
   input  logic               RST,
   fixpoint_mult_pipe_if.slave bus
);

   localparam int W1   = WI1 + WF1;
   localparam int W2   = WI2 + WF2;
   localparam int INTP = fx_int_p(WI1, WI2);
   localparam int FRCP = fx_frc_p(WF1, WF2);
   localparam int WP   = INTP + FRCP;
   localparam int WO   = WIO + WFO;

   logic                 en_s;
   logic                 v1_r;
   logic                 v2_r;
   logic                 v3_r;
   logic signed [W1-1:0] a_r;
   logic signed [W2-1:0] b_r;
   logic signed [WP-1:0] a_ext_s;
   logic signed [WP-1:0] b_ext_s;
   logic signed [WP-1:0] prod_s;
   logic signed [WP-1:0] prod_r;
   logic        [WO-1:0] res_s;
   logic                 ovf_s;
   logic        [WO-1:0] out_r;
   logic                 ovf_r;

   assign en_s          = ~v3_r | bus.out_ready;
   assign bus.in_ready  = en_s;
   assign bus.out_valid = v3_r;
   assign bus.out       = out_r;
   assign bus.OVF       = ovf_r;

   // Operands are sign-extended to the full product width so the product is exact.
   assign a_ext_s = WP'(a_r);
   assign b_ext_s = WP'(b_r);
   assign prod_s  = a_ext_s * b_ext_s;

   // S1: capture the operand pair.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         v1_r <= 1'b0;
         a_r  <= '0;
         b_r  <= '0;
      end else if (en_s) begin
         v1_r <= bus.in_valid;
         if (bus.in_valid) begin
            a_r <= bus.in1;
            b_r <= bus.in2;
         end
      end
   end

   // S2: register the exact signed product.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         v2_r   <= 1'b0;
         prod_r <= '0;
      end else if (en_s) begin
         v2_r <= v1_r;
         if (v1_r) begin
            prod_r <= prod_s;
         end
      end
   end

   fixpoint_resize #(
      .WII (INTP),
      .WFI (FRCP),
      .WIO (WIO),
      .WFO (WFO)
   ) u_resize (
      .din  (prod_r),
      .dout (res_s),
      .ovf  (ovf_s)
   );

   // S3: register formatted result and OVF; data holds across bubbles and stalls.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         v3_r  <= 1'b0;
         out_r <= '0;
         ovf_r <= 1'b0;
      end else if (en_s) begin
         v3_r <= v2_r;
         if (v2_r) begin
            out_r <= res_s;
            ovf_r <= ovf_s;
         end
      end
   end

endmodule
